afifo_read_packer: RTL and testbench

- Read-domain consumer of the async FIFO. Pops WIDTH-bit words from the FIFO's show-ahead read port (`read_data` valid whenever `!empty`; `read_en` pops).
- Packs RATIO consecutive words into one wide beat and presents it on a registered valid/ready stream to downstream read-domain logic.
- Supports a flush request that emits a partial final beat with a word mask.
- Sustains one FIFO pop per cycle when downstream keeps `out_ready` high.

---
 rtl/afifo_read_packer.sv | 117 +++++++++++
 tb/tb_afifo_read_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_read_packer.sv
// Packs RATIO show-ahead FIFO words into one wide beat on a registered valid/ready stream; flush emits a masked partial beat.
// Latency: out_valid rises the cycle after the RATIO-th pop; a flush beat appears two cycles after the flush request at the earliest.
// Backpressure: holds the beat while !out_ready and keeps popping until the accumulator holds RATIO-1 words, then stalls.
module afifo_read_packer #(
    parameter int WIDTH     = 32,
    parameter int RATIO     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                   read_clk,
    input  logic                   read_reset_n,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_read_data,
    output logic                   fifo_read_en,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_mask,
    output logic                   out_last,
    output logic [CNT_WIDTH-1:0]   beat_count,
    output logic                   busy
);
    localparam int IDX_W = $clog2(RATIO);
    localparam int ACC_W = WIDTH * (RATIO - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_wr;
    logic [IDX_W-1:0] idx;
    logic             flush_pending, flush_pending_nxt;
    logic             out_free, pop_full, flush_emit;
    logic [RATIO-1:0] part_mask;

    always_comb begin
        out_free     = !out_valid || out_ready;
        // Gated by reset so the FIFO is never popped while reset is held.
        fifo_read_en = read_reset_n && (state == ACCUM) && !fifo_empty &&
                       ((idx != IDX_LAST) || out_free);
        pop_full     = fifo_read_en && (idx == IDX_LAST);
        flush_emit   = (state == FLUSH) && (idx != '0) && out_free;

        state_nxt         = state;
        flush_pending_nxt = flush_pending || flush;
        if (state == ACCUM) begin
            if (flush || flush_pending)
                state_nxt = FLUSH;
        end else begin
            if ((idx == '0) || out_free) begin
                state_nxt         = ACCUM;
                flush_pending_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        acc_wr    = acc;
        part_mask = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (idx == IDX_W'(k))
                acc_wr[k*WIDTH +: WIDTH] = fifo_read_data;
        end
        for (int k = 0; k < RATIO; k++)
            part_mask[k] = (IDX_W'(k) < idx);
    end

    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state         <= ACCUM;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            flush_pending <= flush_pending_nxt;
        end
    end

    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_mask   <= '0;
            out_last   <= 1'b0;
            beat_count <= '0;
            acc        <= '0;
            idx        <= '0;
        end else begin
            beat_count <= beat_count + CNT_WIDTH'(out_valid && out_ready);
            if (pop_full) begin
                out_data  <= {fifo_read_data, acc};
                out_mask  <= '1;
                out_last  <= 1'b0;
                out_valid <= 1'b1;
                acc       <= '0;
                idx       <= '0;
            end else if (flush_emit) begin
                // Unused accumulator words are already zero, so the tail pads with zeros.
                out_data  <= {{WIDTH{1'b0}}, acc};
                out_mask  <= part_mask;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                acc       <= '0;
                idx       <= '0;
            end else begin
                if (out_ready)
                    out_valid <= 1'b0;
                if (fifo_read_en) begin
                    acc <= acc_wr;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy = (idx != '0) || flush_pending || out_valid;

endmodule

// File: tb/tb_afifo_read_packer.sv
// Self-checking bench for afifo_read_packer: queue-modelled FIFO feeding the DUT, scoreboard of expected beats.
module tb_afifo_read_packer;
    localparam int W = 32;
    localparam int R = 4;
    localparam int C = 16;

    typedef struct {
        logic [W*R-1:0] d;
        logic [R-1:0]   m;
        logic           l;
    } beat_t;

    logic           read_clk;
    logic           read_reset_n;
    logic           fifo_empty;
    logic [W-1:0]   fifo_read_data;
    logic           fifo_read_en;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [W*R-1:0] out_data;
    logic [R-1:0]   out_mask;
    logic           out_last;
    logic [C-1:0]   beat_count;
    logic           busy;

    afifo_read_packer #(.WIDTH(W), .RATIO(R), .CNT_WIDTH(C)) dut (
        .read_clk       (read_clk),
        .read_reset_n   (read_reset_n),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_mask       (out_mask),
        .out_last       (out_last),
        .beat_count     (beat_count),
        .busy           (busy)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    logic [W-1:0] fifo_q[$];
    beat_t        exp_q[$];
    int           acc_cyc[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           pops = 0;
    int           run = 0;
    int           max_run = 0;
    int           cyc = 0;

    task automatic chk(input string tag, input logic [W*R-1:0] got, input logic [W*R-1:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [W*R-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic drive_fifo();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic push_beat(input logic [W*R-1:0] d, input logic [R-1:0] m, input logic l);
        beat_t b;
        b.d = d;
        b.m = m;
        b.l = l;
        exp_q.push_back(b);
    endtask

    // One clock: sample at the falling edge, let the rising edge act, then update the FIFO model.
    task automatic tick();
        logic  pop_now;
        beat_t e;
        @(negedge read_clk);
        pop_now = fifo_read_en;
        if (pop_now && fifo_empty)
            chk("pop_while_empty", 1, 0);
        if (out_valid && out_ready) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_data, 0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", out_data, e.d);
                chk("beat_mask", out_mask, e.m);
                chk("beat_last", out_last, e.l);
            end
        end
        @(posedge read_clk);
        #1;
        cyc++;
        if (pop_now) begin
            pops++;
            run++;
            if (run > max_run) max_run = run;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            drive_fifo();
        end else begin
            run = 0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(fifo_q.size() == 0 && !busy && exp_q.size() == 0) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, (fifo_q.size() == 0 && !busy && exp_q.size() == 0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W*R-1:0] bd;
        logic [W-1:0]   w;
        read_reset_n = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        drive_fifo();
        repeat (3) tick();
        read_reset_n = 1'b1;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_rden", fifo_read_en, 0);
        chk("rst_count", beat_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mask", out_mask, 0);
        chk("rst_data", out_data, 0);

        // Single full beat
        out_ready = 1'b1;
        pops = 0; max_run = 0;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        push_beat(pack4(32'h11, 32'h22, 32'h33, 32'h44), 4'b1111, 1'b0);
        wait_idle("idle_single");
        chk("single_pops", pops, 4);
        chk("single_run", max_run, 4);
        chk("single_count", beat_count, 1);

        // Streaming 12 words
        pops = 0; max_run = 0; acc_cyc.delete();
        for (int i = 0; i < 12; i++) begin
            w = 32'h1000 + i;
            push_word(w);
            bd[(i % 4) * W +: W] = w;
            if (i % 4 == 3) push_beat(bd, 4'b1111, 1'b0);
        end
        wait_idle("idle_stream");
        chk("stream_pops", pops, 12);
        chk("stream_run", max_run, 12);
        chk("stream_count", beat_count, 4);
        chk("stream_nbeats", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("stream_gap0", acc_cyc[1] - acc_cyc[0], 4);
            chk("stream_gap1", acc_cyc[2] - acc_cyc[1], 4);
        end

        // Backpressure with 8 words
        out_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 8; i++) push_word(32'h2000 + i);
        push_beat(pack4(32'h2000, 32'h2001, 32'h2002, 32'h2003), 4'b1111, 1'b0);
        push_beat(pack4(32'h2004, 32'h2005, 32'h2006, 32'h2007), 4'b1111, 1'b0);
        repeat (20) tick();
        chk("bp_pops", pops, 7);
        chk("bp_valid", out_valid, 1);
        chk("bp_rden", fifo_read_en, 0);
        chk("bp_hold_data", out_data, pack4(32'h2000, 32'h2001, 32'h2002, 32'h2003));
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_pops_after", pops, 8);
        chk("bp_valid2", out_valid, 1);
        chk("bp_data2", out_data, pack4(32'h2004, 32'h2005, 32'h2006, 32'h2007));
        wait_idle("idle_bp");
        chk("bp_count", beat_count, 6);

        // Partial flush with two words
        push_word(32'hA); push_word(32'hB);
        repeat (4) tick();
        chk("pf_busy_partial", busy, 1);
        chk("pf_novalid", out_valid, 0);
        push_beat(pack4(32'hA, 32'hB, 32'h0, 32'h0), 4'b0011, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle("idle_pflush");
        chk("pf_count", beat_count, 7);

        // Flush with nothing accumulated
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("ef_busy", busy, 0);
        chk("ef_valid", out_valid, 0);
        repeat (3) tick();
        chk("ef_count", beat_count, 7);

        // Flush on the cycle of the 4th pop
        for (int i = 0; i < 4; i++) push_word(32'h3000 + i);
        push_beat(pack4(32'h3000, 32'h3001, 32'h3002, 32'h3003), 4'b1111, 1'b0);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_idle("idle_cflush");
        repeat (3) tick();
        chk("cf_count", beat_count, 8);

        // Reset with a held beat and two accumulated words
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'h4000 + i);
        repeat (10) tick();
        chk("mr_valid_pre", out_valid, 1);
        chk("mr_fifo_drained", fifo_q.size(), 0);
        read_reset_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_count", beat_count, 0);
        pops = 0;
        for (int i = 0; i < 4; i++) push_word(32'h5000 + i);
        #1;
        chk("mr_rden", fifo_read_en, 0);
        repeat (2) tick();
        chk("mr_nopop", pops, 0);
        read_reset_n = 1'b1;
        push_beat(pack4(32'h5000, 32'h5001, 32'h5002, 32'h5003), 4'b1111, 1'b0);
        out_ready = 1'b1;
        wait_idle("idle_after_rst");
        chk("mr_count_after", beat_count, 1);
        chk("mr_pops_after", pops, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
